// File: rtl/halt_dump_monitor_pkg.sv
// Shared types and helpers for the halt/dump monitor.
//   state_e : controller states (RUN -> FETCH <-> SEND -> DONE)
//   idx_w() : index width for a register file of n entries, minimum 1 bit
package halt_dump_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/halt_dump_monitor_if.sv
// Valid/ready dump stream carrying one register-file entry per handshake.
//   dump_valid : entry valid (monitor -> consumer)
//   dump_ready : consumer accepts entry (consumer -> monitor)
//   dump_idx   : register index of the entry
//   dump_data  : register value of the entry
// master = monitor side, slave = consumer side.
interface halt_dump_monitor_if #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned DATA_W = 32
) ();

  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/halt_dump_monitor_sat_counter.sv
// Saturating up-counter used for the cycle counter and each event channel.
//   clk, reset : clock, synchronous active-high reset
//   inc_i      : count this cycle
//   freeze_i   : hold the current value regardless of inc_i
//   count_o    : counter value, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc_i && !freeze_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/halt_dump_monitor.sv
// Cycle/event counters with halt- or watchdog-triggered register-file dump.
// Counts cycles and event strobes while the CPU runs; on halt (or watchdog
// expiry) the counters freeze and every register-file entry is streamed out
// through the spare read port over a valid/ready interface.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   is_halted    : CPU halt level
//   event_in     : per-cycle event strobes, one per counter channel
//   rf_rd_addr   : register-file read address (always the current index)
//   rf_rd_data   : combinational read data for rf_rd_addr
//   dump_if      : dump stream (valid/ready/idx/data), master side
//   total_cycle  : cycle counter
//   event_cnt    : event counters, channel k at [k*CNT_W +: CNT_W]
//   timed_out    : dump was triggered by the watchdog
//   done         : dump complete, sticky until reset
//
// Build option: HALT_DUMP_SKIP_ZERO_EN - entries reading as zero are skipped
// (one cycle each) instead of being sent.
module halt_dump_monitor
  import halt_dump_pkg::*;
#(
  parameter  int unsigned NUM_REGS   = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned CNT_W      = 32,
  parameter  int unsigned NUM_EVENTS = 4,
  parameter  int unsigned TIMEOUT    = 100000,
  localparam int unsigned IDX_W      = idx_w(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        is_halted,
  input  logic [NUM_EVENTS-1:0]       event_in,
  output logic [IDX_W-1:0]            rf_rd_addr,
  input  logic [DATA_W-1:0]           rf_rd_data,
  halt_dump_monitor_if.master         dump_if,
  output logic [CNT_W-1:0]            total_cycle,
  output logic [NUM_EVENTS*CNT_W-1:0] event_cnt,
  output logic                        timed_out,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  // TIMEOUT must fit in CNT_W bits for the watchdog to fire at the right count.
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
  localparam bit               WD_EN    = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              timed_out_q, timed_out_d;
  logic              freeze;
  logic              wd_hit;
  logic              last_idx;

  // A halt edge must not count, so the halt level freezes counters directly;
  // the watchdog edge still counts, landing total_cycle exactly on TIMEOUT.
  assign freeze   = (state_q != RUN) || is_halted;
  assign wd_hit   = WD_EN && (total_cycle == WD_LAST);
  assign last_idx = (idx_q == LAST_IDX);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (1'b1),
    .freeze_i (freeze),
    .count_o  (total_cycle)
  );

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_event_cnt
    sat_counter #(.CNT_W(CNT_W)) u_event_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc_i    (event_in[k]),
      .freeze_i (freeze),
      .count_o  (event_cnt[k*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      RUN: begin
        // Halt has priority over a coincident watchdog expiry.
        if (is_halted) begin
          state_d = FETCH;
          idx_d   = '0;
        end else if (wd_hit) begin
          state_d     = FETCH;
          idx_d       = '0;
          timed_out_d = 1'b1;
        end
      end
      FETCH: begin
`ifdef HALT_DUMP_SKIP_ZERO_EN
        if (rf_rd_data == '0) begin
          if (last_idx) state_d = DONE;
          else          idx_d   = idx_q + IDX_W'(1);
        end else begin
          dump_data_d = rf_rd_data;
          dump_idx_d  = idx_q;
          state_d     = SEND;
        end
`else
        dump_data_d = rf_rd_data;
        dump_idx_d  = idx_q;
        state_d     = SEND;
`endif
      end
      SEND: begin
        if (dump_if.dump_ready) begin
          if (last_idx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign rf_rd_addr         = idx_q;
  assign dump_if.dump_valid = (state_q == SEND);
  assign dump_if.dump_idx   = dump_idx_q;
  assign dump_if.dump_data  = dump_data_q;
  assign timed_out          = timed_out_q;
  assign done               = (state_q == DONE);

endmodule

// File: tb/tb_halt_dump_monitor.sv
// Self-checking bench for halt_dump_monitor: main instance (default sizes),
// a small watchdog instance (TIMEOUT=50) and a narrow-counter instance for
// saturation with the watchdog disabled.
module tb_halt_dump_monitor;

`ifdef HALT_DUMP_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- main instance ----------------
  logic         reset, is_halted;
  logic [3:0]   event_in;
  logic [4:0]   rf_rd_addr;
  logic [31:0]  rf_rd_data;
  logic [31:0]  total_cycle;
  logic [127:0] event_cnt;
  logic         timed_out, done;
  logic [31:0]  rf [32];

  assign rf_rd_data = rf[rf_rd_addr];

  halt_dump_monitor_if #(.IDX_W(5), .DATA_W(32)) dif ();

  halt_dump_monitor #(.NUM_REGS(32), .DATA_W(32), .CNT_W(32), .NUM_EVENTS(4)) dut (
    .clk(clk), .reset(reset), .is_halted(is_halted), .event_in(event_in),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .dump_if(dif.master),
    .total_cycle(total_cycle), .event_cnt(event_cnt), .timed_out(timed_out), .done(done)
  );

  // ---------------- watchdog instance ----------------
  logic        reset_w, halt_w;
  logic [0:0]  ev_w;
  logic [1:0]  addr_w;
  logic [31:0] data_w, tc_w, ec_w;
  logic        to_w, done_w;
  logic [31:0] rf_w [4];

  assign data_w = rf_w[addr_w];
  assign ev_w   = 1'b0;

  halt_dump_monitor_if #(.IDX_W(2), .DATA_W(32)) dif_w ();
  assign dif_w.dump_ready = 1'b1;

  halt_dump_monitor #(.NUM_REGS(4), .DATA_W(32), .CNT_W(32), .NUM_EVENTS(1), .TIMEOUT(50)) dut_wd (
    .clk(clk), .reset(reset_w), .is_halted(halt_w), .event_in(ev_w),
    .rf_rd_addr(addr_w), .rf_rd_data(data_w), .dump_if(dif_w.master),
    .total_cycle(tc_w), .event_cnt(ec_w), .timed_out(to_w), .done(done_w)
  );

  // ---------------- saturation instance ----------------
  logic        reset_s, halt_s;
  logic [0:0]  ev_s;
  logic [0:0]  addr_s;
  logic [31:0] data_s;
  logic [2:0]  tc_s, ec_s;
  logic        to_s, done_s;

  assign data_s = 32'hA5 ^ {31'b0, addr_s};

  halt_dump_monitor_if #(.IDX_W(1), .DATA_W(32)) dif_s ();
  assign dif_s.dump_ready = 1'b1;

  halt_dump_monitor #(.NUM_REGS(2), .DATA_W(32), .CNT_W(3), .NUM_EVENTS(1), .TIMEOUT(0)) dut_sat (
    .clk(clk), .reset(reset_s), .is_halted(halt_s), .event_in(ev_s),
    .rf_rd_addr(addr_s), .rf_rd_data(data_s), .dump_if(dif_s.master),
    .total_cycle(tc_s), .event_cnt(ec_s), .timed_out(to_s), .done(done_s)
  );

  // ---------------- reference model state ----------------
  int unsigned exp_total;
  int unsigned exp_ev [4];

  task automatic apply_reset();
    reset = 1'b1; is_halted = 1'b0; event_in = '0; dif.dump_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_total = 0;
    for (int k = 0; k < 4; k++) exp_ev[k] = 0;
  endtask

  // One running cycle: the model counts every non-halted edge and its strobes.
  task automatic step(input logic [3:0] ev);
    is_halted = 1'b0; event_in = ev;
    @(posedge clk); #1;
    exp_total++;
    for (int k = 0; k < 4; k++) if (ev[k]) exp_ev[k]++;
  endtask

  task automatic run_cycles(input int n, input bit rand_ev);
    for (int i = 0; i < n; i++) step(rand_ev ? 4'($urandom) : 4'b0);
  endtask

  // Halt edge: counters must hold the model's values and stay frozen.
  task automatic do_halt();
    is_halted = 1'b1; event_in = 4'($urandom);
    @(posedge clk); #1;
    is_halted = 1'($urandom);
    event_in  = 4'($urandom);
    n_total++;
    if (total_cycle !== exp_total) $display("FAIL halt_total: got %0d expected %0d", total_cycle, exp_total);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (event_cnt[k*32 +: 32] !== exp_ev[k])
        $display("FAIL halt_event%0d: got %0d expected %0d", k, event_cnt[k*32 +: 32], exp_ev[k]);
      else n_pass++;
    end
    n_total++;
    if (timed_out !== 1'b0 || done !== 1'b0 || dif.dump_valid !== 1'b0)
      $display("FAIL halt_flags: got to=%b done=%b valid=%b expected 0 0 0", timed_out, done, dif.dump_valid);
    else n_pass++;
  endtask

  // Drain the dump, comparing each handshake with the expected entry list.
  task automatic run_dump(input bit rand_ready, input bit check_time);
    logic [36:0] q[$];
    logic [4:0]  hold_idx;
    logic [31:0] hold_data;
    bit held;
    int stall, cyc, sent, n_skip, exp_sent;
    n_skip = 0;
    for (int i = 0; i < 32; i++) begin
      if (SKIP_ZERO && rf[i] == 32'd0) n_skip++;
      else q.push_back({5'(i), rf[i]});
    end
    exp_sent = q.size();
    stall = rand_ready ? int'($urandom_range(1, 4)) : 0;
    cyc = 0; sent = 0; held = 0;
    while (!done && cyc < 400) begin
      dif.dump_ready = (stall == 0);
      if (dif.dump_valid) begin
        if (stall > 0) begin
          stall--; held = 1;
          hold_idx = dif.dump_idx; hold_data = dif.dump_data;
        end else begin
          n_total++;
          if (q.size() == 0)
            $display("FAIL dump_extra: got idx=%0d data=%h expected no more entries", dif.dump_idx, dif.dump_data);
          else if ({dif.dump_idx, dif.dump_data} !== q[0])
            $display("FAIL dump_entry: got idx=%0d data=%h expected idx=%0d data=%h",
                     dif.dump_idx, dif.dump_data, q[0][36:32], q[0][31:0]);
          else n_pass++;
          if (q.size() > 0) void'(q.pop_front());
          sent++;
          stall = rand_ready ? int'($urandom_range(1, 4)) : 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (held) begin
        n_total++;
        if (dif.dump_valid !== 1'b1 || dif.dump_idx !== hold_idx || dif.dump_data !== hold_data)
          $display("FAIL dump_hold: got v=%b idx=%0d data=%h expected v=1 idx=%0d data=%h",
                   dif.dump_valid, dif.dump_idx, dif.dump_data, hold_idx, hold_data);
        else n_pass++;
        held = 0;
      end
    end
    n_total++;
    if (done !== 1'b1 || dif.dump_valid !== 1'b0)
      $display("FAIL dump_done: got done=%b valid=%b after %0d cycles expected done=1 valid=0", done, dif.dump_valid, cyc);
    else n_pass++;
    n_total++;
    if (sent !== exp_sent) $display("FAIL dump_count: got %0d handshakes expected %0d", sent, exp_sent);
    else n_pass++;
    if (check_time) begin
      n_total++;
      if (cyc !== 2*exp_sent + n_skip)
        $display("FAIL dump_latency: got done after %0d edges expected %0d", cyc, 2*exp_sent + n_skip);
      else n_pass++;
    end
    n_total++;
    if (total_cycle !== exp_total) $display("FAIL frozen_total: got %0d expected %0d", total_cycle, exp_total);
    else n_pass++;
    dif.dump_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_total++; if (total_cycle !== 32'd0) $display("FAIL rst_total: got %0d expected 0", total_cycle); else n_pass++;
    n_total++; if (event_cnt !== 128'd0) $display("FAIL rst_events: got %h expected 0", event_cnt); else n_pass++;
    n_total++; if (dif.dump_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", dif.dump_valid); else n_pass++;
    n_total++; if (dif.dump_idx !== 5'd0 || dif.dump_data !== 32'd0)
      $display("FAIL rst_dump: got idx=%0d data=%h expected 0 0", dif.dump_idx, dif.dump_data); else n_pass++;
    n_total++; if (timed_out !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_flags: got to=%b done=%b expected 0 0", timed_out, done); else n_pass++;
    n_total++; if (rf_rd_addr !== 5'd0) $display("FAIL rst_addr: got %0d expected 0", rf_rd_addr); else n_pass++;
  endtask

  task automatic test_basic_dump();
    for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'h1;
    apply_reset();
    run_cycles(10, 0);
    do_halt();
    n_total++; if (total_cycle !== 32'd10) $display("FAIL basic_total: got %0d expected 10", total_cycle); else n_pass++;
    run_dump(0, 1);
  endtask

  task automatic test_events();
    logic [3:0] pat [14];
    pat = '{4'h1, 4'h5, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4};
    apply_reset();
    for (int i = 0; i < 14; i++) step(pat[i]);
    do_halt();
    n_total++;
    if (event_cnt[31:0] !== 32'd7 || event_cnt[63:32] !== 32'd0 || event_cnt[95:64] !== 32'd5 || event_cnt[127:96] !== 32'd0)
      $display("FAIL events_pattern: got %0d %0d %0d %0d expected 7 0 5 0",
               event_cnt[31:0], event_cnt[63:32], event_cnt[95:64], event_cnt[127:96]);
    else n_pass++;
    run_dump(0, 1);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      apply_reset();
      run_cycles(int'($urandom_range(5, 40)), 1);
      do_halt();
      run_dump(1, 0);
    end
  endtask

  task automatic test_sparse();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = $urandom | 32'h1;
    rf[5] = $urandom | 32'h1;
    apply_reset();
    run_cycles(4, 1);
    do_halt();
    run_dump(0, 1);
  endtask

  task automatic test_reset_mid_dump();
    int guard;
    for (int i = 0; i < 32; i++) rf[i] = $urandom | 32'h1;
    apply_reset();
    run_cycles(6, 1);
    do_halt();
    guard = 0;
    dif.dump_ready = 1'b1;
    while (!(dif.dump_valid === 1'b1 && dif.dump_idx === 5'd7) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    n_total++; if (guard >= 100) $display("FAIL mid_reach_idx7: got timeout expected SEND at idx 7"); else n_pass++;
    dif.dump_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (total_cycle !== 32'd0 || event_cnt !== 128'd0 || dif.dump_valid !== 1'b0 || dif.dump_idx !== 5'd0 ||
        dif.dump_data !== 32'd0 || timed_out !== 1'b0 || done !== 1'b0 || rf_rd_addr !== 5'd0)
      $display("FAIL mid_reset_outputs: got tc=%0d v=%b idx=%0d data=%h to=%b done=%b addr=%0d expected all 0",
               total_cycle, dif.dump_valid, dif.dump_idx, dif.dump_data, timed_out, done, rf_rd_addr);
    else n_pass++;
    reset = 1'b0;
    exp_total = 0;
    for (int k = 0; k < 4; k++) exp_ev[k] = 0;
    run_cycles(3, 1);
    n_total++;
    if (total_cycle !== exp_total || event_cnt[31:0] !== exp_ev[0] || event_cnt[127:96] !== exp_ev[3])
      $display("FAIL mid_restart: got tc=%0d ev0=%0d ev3=%0d expected %0d %0d %0d",
               total_cycle, event_cnt[31:0], event_cnt[127:96], exp_total, exp_ev[0], exp_ev[3]);
    else n_pass++;
    n_total++; if (dif.dump_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_restart_state: got v=%b done=%b expected 0 0", dif.dump_valid, done); else n_pass++;
  endtask

  task automatic test_watchdog();
    int seen;
    for (int i = 0; i < 4; i++) rf_w[i] = $urandom | 32'h1;
    // Run 1: no halt, watchdog fires at 50.
    reset_w = 1'b1; halt_w = 1'b0;
    @(posedge clk); #1; reset_w = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    n_total++; if (tc_w !== 32'd49 || to_w !== 1'b0)
      $display("FAIL wd_before: got tc=%0d to=%b expected 49 0", tc_w, to_w); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (tc_w !== 32'd50 || to_w !== 1'b1 || done_w !== 1'b0)
      $display("FAIL wd_fire: got tc=%0d to=%b done=%b expected 50 1 0", tc_w, to_w, done_w); else n_pass++;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      halt_w = 1'($urandom);
      @(posedge clk); #1;
      if (dif_w.dump_valid === 1'b1) begin
        n_total++;
        if (dif_w.dump_idx !== 2'(seen) || dif_w.dump_data !== rf_w[seen])
          $display("FAIL wd_entry: got idx=%0d data=%h expected idx=%0d data=%h", dif_w.dump_idx, dif_w.dump_data, seen, rf_w[seen]);
        else n_pass++;
        if (seen < 3) seen++;
      end
    end
    n_total++; if (done_w !== 1'b1 || tc_w !== 32'd50 || to_w !== 1'b1 || ec_w !== 32'd0)
      $display("FAIL wd_done: got done=%b tc=%0d to=%b ev=%0d expected 1 50 1 0", done_w, tc_w, to_w, ec_w); else n_pass++;
    // Run 2: halt on the same edge as the timeout; halt wins.
    reset_w = 1'b1; halt_w = 1'b0;
    @(posedge clk); #1; reset_w = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    halt_w = 1'b1;
    @(posedge clk); #1;
    n_total++; if (tc_w !== 32'd49 || to_w !== 1'b0)
      $display("FAIL wd_coincide: got tc=%0d to=%b expected 49 0", tc_w, to_w); else n_pass++;
    repeat (8) @(posedge clk);
    #1;
    n_total++; if (done_w !== 1'b1 || to_w !== 1'b0)
      $display("FAIL wd_coincide_done: got done=%b to=%b expected 1 0", done_w, to_w); else n_pass++;
  endtask

  task automatic test_saturation();
    reset_s = 1'b1; halt_s = 1'b0; ev_s = 1'b0;
    @(posedge clk); #1; reset_s = 1'b0; ev_s = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_total++; if (tc_s !== 3'd7 || ec_s !== 3'd7)
      $display("FAIL sat_value: got tc=%0d ev=%0d expected 7 7", tc_s, ec_s); else n_pass++;
    n_total++; if (to_s !== 1'b0 || dif_s.dump_valid !== 1'b0 || done_s !== 1'b0)
      $display("FAIL sat_no_watchdog: got to=%b v=%b done=%b expected 0 0 0", to_s, dif_s.dump_valid, done_s); else n_pass++;
    halt_s = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    n_total++; if (done_s !== 1'b1 || tc_s !== 3'd7)
      $display("FAIL sat_dump_done: got done=%b tc=%0d expected 1 7", done_s, tc_s); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; reset_w = 1'b1; reset_s = 1'b1;
    is_halted = 1'b0; halt_w = 1'b0; halt_s = 1'b0; ev_s = 1'b0;
    event_in = '0; dif.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < 4; i++) rf_w[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_dump();
    test_events();
    test_backpressure();
    test_sparse();
    test_reset_mid_dump();
    test_watchdog();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion expected finish within time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
